// File: rtl/oci_debug_mem_arbiter.sv
// Arbitrates one single-port RAM between an OCI debug port and a CPU Avalon-MM slave.
// Ports: clk/reset; dbg_* pointer-based debug access (load/req/done/overrun);
//   debugack gives debug strict priority; cpu_* Avalon-MM slave; ram_* single-port RAM
//   with one-cycle read latency.
module oci_debug_mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        dbg_addr_load,
    input  logic [7:0]  dbg_addr,
    input  logic        dbg_req,
    input  logic        dbg_wr,
    input  logic [31:0] dbg_wdata,
    input  logic        dbg_auto_inc,
    output logic [31:0] dbg_rdata,
    output logic        dbg_done,
    output logic        dbg_overrun,
    input  logic        debugack,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_address,
    input  logic [31:0] cpu_writedata,
    input  logic [3:0]  cpu_byteenable,
    output logic [31:0] cpu_readdata,
    output logic        cpu_waitrequest,
    output logic [7:0]  ram_addr,
    output logic        ram_wren,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_be,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        DBG_ACC,
        DBG_RD,
        CPU_ACC,
        CPU_RD
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        dbg_pend;
    logic        pend_wr;
    logic [31:0] pend_wdata;
    logic [7:0]  ptr;
    logic [7:0]  acc_addr;
    logic        acc_wr;
    logic [31:0] acc_wdata;
    logic        acc_cpu_rd;
    logic        last_dbg;
    logic        cpu_req;
    logic        dbg_grant;
    logic        cpu_grant;
    logic        dbg_drop;
    logic        cpu_done_now;

    assign cpu_req = cpu_read | cpu_write;

    // Tie-break: debugack forces debug, otherwise whoever was not granted last.
    always_comb begin
        dbg_grant = 1'b0;
        cpu_grant = 1'b0;
        if (state == IDLE) begin
            if (dbg_pend && cpu_req) begin
                if (debugack || !last_dbg) dbg_grant = 1'b1;
                else                       cpu_grant = 1'b1;
            end else if (dbg_pend) begin
                dbg_grant = 1'b1;
            end else if (cpu_req) begin
                cpu_grant = 1'b1;
            end
        end
    end

    // A new request can only be held if the slot frees this cycle or was empty.
    assign dbg_drop = dbg_req & dbg_pend & ~dbg_grant;

    always_comb begin
        state_nx     = state;
        ram_addr     = acc_addr;
        ram_wren     = 1'b0;
        ram_wdata    = acc_wdata;
        ram_be       = 4'hF;
        cpu_done_now = 1'b0;
        case (state)
            IDLE: begin
                if (dbg_grant)      state_nx = DBG_ACC;
                else if (cpu_grant) state_nx = CPU_ACC;
            end
            DBG_ACC: begin
                ram_wren = acc_wr;
                state_nx = acc_wr ? IDLE : DBG_RD;
            end
            DBG_RD: state_nx = IDLE;
            CPU_ACC: begin
                ram_addr     = cpu_address;
                ram_wdata    = cpu_writedata;
                ram_be       = cpu_byteenable;
                ram_wren     = ~acc_cpu_rd;
                cpu_done_now = ~acc_cpu_rd;
                state_nx     = acc_cpu_rd ? CPU_RD : IDLE;
            end
            CPU_RD: begin
                cpu_done_now = 1'b1;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Reset aborts whatever access is in flight this very cycle.
        if (reset) begin
            ram_wren     = 1'b0;
            cpu_done_now = 1'b0;
        end
    end

    assign cpu_waitrequest = cpu_req & ~cpu_done_now;
    assign cpu_readdata    = ram_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            dbg_pend    <= 1'b0;
            pend_wr     <= 1'b0;
            pend_wdata  <= '0;
            ptr         <= '0;
            acc_addr    <= '0;
            acc_wr      <= 1'b0;
            acc_wdata   <= '0;
            acc_cpu_rd  <= 1'b0;
            last_dbg    <= 1'b0;
            dbg_rdata   <= '0;
            dbg_done    <= 1'b0;
            dbg_overrun <= 1'b0;
        end else begin
            state <= state_nx;
            if (dbg_req && !dbg_drop) begin
                dbg_pend   <= 1'b1;
                pend_wr    <= dbg_wr;
                pend_wdata <= dbg_wdata;
            end else if (dbg_grant) begin
                dbg_pend <= 1'b0;
            end
            if (dbg_drop) dbg_overrun <= 1'b1;
            // Access bundle is copied so a request accepted on the grant
            // cycle cannot corrupt the access just granted.
            if (dbg_grant) begin
                acc_addr  <= ptr;
                acc_wr    <= pend_wr;
                acc_wdata <= pend_wdata;
                last_dbg  <= 1'b1;
            end
            if (cpu_grant) begin
                acc_cpu_rd <= cpu_read;
                last_dbg   <= 1'b0;
            end
            if (dbg_addr_load)                  ptr <= dbg_addr;
            else if (dbg_grant && dbg_auto_inc) ptr <= ptr + 8'd1;
            dbg_done <= ((state == DBG_ACC) && acc_wr) || (state == DBG_RD);
            if (state == DBG_RD) dbg_rdata <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_oci_debug_mem_arbiter.sv
// Testbench for oci_debug_mem_arbiter: transaction-level model of RAM contents,
// pointer and expected access order, checked against the DUT every cycle.
module tb_oci_debug_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        dbg_addr_load;
    logic [7:0]  dbg_addr;
    logic        dbg_req;
    logic        dbg_wr;
    logic [31:0] dbg_wdata;
    logic        dbg_auto_inc;
    logic [31:0] dbg_rdata;
    logic        dbg_done;
    logic        dbg_overrun;
    logic        debugack;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_address;
    logic [31:0] cpu_writedata;
    logic [3:0]  cpu_byteenable;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata;

    oci_debug_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .dbg_addr_load(dbg_addr_load), .dbg_addr(dbg_addr),
        .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_wdata(dbg_wdata),
        .dbg_auto_inc(dbg_auto_inc), .dbg_rdata(dbg_rdata),
        .dbg_done(dbg_done), .dbg_overrun(dbg_overrun),
        .debugack(debugack),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_address(cpu_address), .cpu_writedata(cpu_writedata),
        .cpu_byteenable(cpu_byteenable), .cpu_readdata(cpu_readdata),
        .cpu_waitrequest(cpu_waitrequest),
        .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata),
        .ram_be(ram_be), .ram_rdata(ram_rdata)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    typedef struct {
        bit         rd;
        logic [7:0] addr;
    } dq_t;

    logic [31:0] ram [256];
    logic [31:0] mdl_mem [256];
    logic [7:0]  mdl_ptr;
    wr_t         exp_wr [$];
    dq_t         exp_dbg [$];
    int          n_chk;
    int          n_fail;
    int          done_cnt;
    int          lat;
    int          lat_c;
    int          base;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_val(input logic [7:0] i);
        return {8'hC0, i, ~i, i};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic void push_wr(input logic [7:0] a, input logic [31:0] d,
                                    input logic [3:0] be);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.be   = be;
        exp_wr.push_back(w);
    endfunction

    // Model of a granted debug access: uses the current pointer, then
    // post-increments it when auto-increment is on.
    function automatic void expect_dbg(input bit rd, input logic [31:0] d);
        dq_t q;
        q.rd   = rd;
        q.addr = mdl_ptr;
        exp_dbg.push_back(q);
        if (!rd) push_wr(mdl_ptr, d, 4'hF);
        if (dbg_auto_inc) mdl_ptr = mdl_ptr + 8'd1;
    endfunction

    task automatic ptr_load(input logic [7:0] v);
        dbg_addr_load = 1'b1;
        dbg_addr      = v;
        tick;
        dbg_addr_load = 1'b0;
        mdl_ptr       = v;
    endtask

    task automatic dbg_op(input bit wr, input logic [31:0] d, output int l);
        expect_dbg(!wr, d);
        dbg_wr    = wr;
        dbg_wdata = d;
        dbg_req   = 1'b1;
        tick;
        dbg_req = 1'b0;
        l = 1;
        @(negedge clk);
        while (!dbg_done && l < 40) begin
            l++;
            @(negedge clk);
        end
        tick;
    endtask

    task automatic cpu_op(input bit rd, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] be,
                          input bit push, output int l);
        if (push && !rd) push_wr(a, d, be);
        cpu_read       = rd;
        cpu_write      = !rd;
        cpu_address    = a;
        cpu_writedata  = d;
        cpu_byteenable = be;
        l = 1;
        @(negedge clk);
        while (cpu_waitrequest && l < 60) begin
            l++;
            @(negedge clk);
        end
        tick;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    task automatic wait_dones(input int target, input string nm);
        int n;
        n = 0;
        while (done_cnt < target && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(nm, done_cnt, target);
        tick;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        reset   = 1'b0;
        mdl_ptr = 8'h00;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        done_cnt = 0;
        mdl_ptr = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mdl_mem[i] = init_val(8'(i));
        end
        reset = 1'b1;
        dbg_addr_load = 1'b0;
        dbg_addr = 8'h00;
        dbg_req = 1'b0;
        dbg_wr = 1'b0;
        dbg_wdata = '0;
        dbg_auto_inc = 1'b1;
        debugack = 1'b0;
        cpu_read = 1'b1;
        cpu_write = 1'b0;
        cpu_address = 8'h00;
        cpu_writedata = '0;
        cpu_byteenable = 4'h0;

        // Behavioural RAM with one-cycle read latency.
        fork
            begin
                for (int i = 0; i < 256; i++) ram[i] = init_val(8'(i));
                forever begin
                    @(posedge clk);
                    if (ram_wren) begin
                        for (int b = 0; b < 4; b++) begin
                            if (ram_be[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
                        end
                    end
                    ram_rdata <= ram[ram_addr];
                end
            end
            forever begin
                @(negedge clk);
                if (ram_wren) begin
                    if (exp_wr.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_wren actual=addr %h required=no write", ram_addr);
                    end else begin
                        wr_t e;
                        e = exp_wr.pop_front();
                        chk("wr_addr", {24'h0, ram_addr}, {24'h0, e.addr});
                        chk("wr_data", ram_wdata, e.data);
                        chk("wr_be", {28'h0, ram_be}, {28'h0, e.be});
                        for (int b = 0; b < 4; b++) begin
                            if (e.be[b]) mdl_mem[e.addr][8*b +: 8] = e.data[8*b +: 8];
                        end
                    end
                end
                if (dbg_done) begin
                    done_cnt++;
                    if (exp_dbg.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_dbg_done actual=1 required=0");
                    end else begin
                        dq_t q;
                        q = exp_dbg.pop_front();
                        if (q.rd) chk("dbg_rdata", dbg_rdata, mdl_mem[q.addr]);
                    end
                end
                if (cpu_read && !cpu_waitrequest && !reset) begin
                    chk("cpu_readdata", cpu_readdata, mdl_mem[cpu_address]);
                end
            end
        join_none

        // Reset values, with a CPU read held to observe waitrequest.
        tick;
        tick;
        chk("rst_wren", {31'h0, ram_wren}, 32'h0);
        chk("rst_done", {31'h0, dbg_done}, 32'h0);
        chk("rst_overrun", {31'h0, dbg_overrun}, 32'h0);
        chk("rst_rdata", dbg_rdata, 32'h0);
        chk("rst_waitreq", {31'h0, cpu_waitrequest}, 32'h1);
        cpu_read = 1'b0;
        reset = 1'b0;
        tick;

        // Pointer load, write with auto-increment.
        ptr_load(8'h10);
        dbg_op(1'b1, 32'hDEADBEEF, lat);
        chk("dbg_wr_latency", lat, 3);
        chk("ram_10", ram[8'h10], 32'hDEADBEEF);
        dbg_op(1'b1, 32'h11111111, lat);
        chk("ram_11", ram[8'h11], 32'h11111111);
        dbg_op(1'b0, 32'h0, lat);
        chk("dbg_rd_latency", lat, 4);
        chk("rdata_12", dbg_rdata, 32'hC012ED12);

        // Pointer wrap 8'hFF -> 8'h00.
        ptr_load(8'hFF);
        dbg_op(1'b0, 32'h0, lat);
        chk("rdata_ff", dbg_rdata, 32'hC0FF00FF);
        dbg_op(1'b0, 32'h0, lat);
        chk("rdata_00", dbg_rdata, 32'hC000FF00);

        // Uncontended CPU write and read.
        cpu_op(1'b0, 8'h30, 32'h12345678, 4'hF, 1'b1, lat);
        chk("cpu_wr_latency", lat, 2);
        cpu_op(1'b1, 8'h30, 32'h0, 4'h0, 1'b0, lat);
        chk("cpu_rd_latency", lat, 3);
        chk("ram_30", ram[8'h30], 32'h12345678);

        // Load on the grant cycle wins; granted access keeps the old pointer.
        expect_dbg(1'b0, 32'hAAAA0001);
        base = done_cnt;
        dbg_wr = 1'b1;
        dbg_wdata = 32'hAAAA0001;
        dbg_req = 1'b1;
        tick;
        dbg_req = 1'b0;
        dbg_addr_load = 1'b1;
        dbg_addr = 8'h40;
        tick;
        dbg_addr_load = 1'b0;
        mdl_ptr = 8'h40;
        wait_dones(base + 1, "load_grant_done");
        chk("ram_01", ram[8'h01], 32'hAAAA0001);
        dbg_op(1'b1, 32'hBBBB0040, lat);
        chk("ram_40", ram[8'h40], 32'hBBBB0040);

        // Ties: first after reset goes to debug, then to the one not granted last.
        do_reset;
        base = done_cnt;
        expect_dbg(1'b1, 32'h0);
        dbg_wr = 1'b0;
        dbg_req = 1'b1;
        tick;
        dbg_req = 1'b0;
        cpu_op(1'b1, 8'h30, 32'h0, 4'h0, 1'b0, lat);
        chk("tie1_cpu_latency", lat, 6);
        wait_dones(base + 1, "tie1_done");

        dbg_op(1'b1, 32'h0000B001, lat);
        base = done_cnt;
        push_wr(8'h50, 32'h50505050, 4'hF);
        expect_dbg(1'b0, 32'h0000B002);
        dbg_wr = 1'b1;
        dbg_wdata = 32'h0000B002;
        dbg_req = 1'b1;
        tick;
        dbg_req = 1'b0;
        cpu_op(1'b0, 8'h50, 32'h50505050, 4'hF, 1'b0, lat);
        chk("tie2_cpu_latency", lat, 2);
        wait_dones(base + 1, "tie2_done");

        cpu_op(1'b0, 8'h51, 32'h51515151, 4'hF, 1'b1, lat);
        base = done_cnt;
        expect_dbg(1'b0, 32'h0000B003);
        push_wr(8'h52, 32'h52525252, 4'hF);
        dbg_wdata = 32'h0000B003;
        dbg_req = 1'b1;
        tick;
        dbg_req = 1'b0;
        cpu_op(1'b0, 8'h52, 32'h52525252, 4'hF, 1'b0, lat);
        chk("tie3_cpu_latency", lat, 4);
        wait_dones(base + 1, "tie3_done");

        // debugack: back-to-back debug reads hold off a CPU byte write.
        debugack = 1'b1;
        ptr_load(8'h80);
        base = done_cnt;
        fork
            begin
                expect_dbg(1'b1, 32'h0);
                dbg_wr = 1'b0;
                dbg_req = 1'b1;
                tick;
                expect_dbg(1'b1, 32'h0);
                tick;
                dbg_req = 1'b0;
                tick;
                tick;
                expect_dbg(1'b1, 32'h0);
                dbg_req = 1'b1;
                tick;
                dbg_req = 1'b0;
            end
            begin
                tick;
                cpu_op(1'b0, 8'h20, 32'h5555AAAA, 4'b0011, 1'b1, lat_c);
            end
        join
        chk("ack_cpu_latency", lat_c, 11);
        wait_dones(base + 3, "ack_three_done");
        chk("ram_20", ram[8'h20], 32'hC020AAAA);
        debugack = 1'b0;

        // Second request while the slot is full and a CPU read runs is dropped.
        chk("overrun_before", {31'h0, dbg_overrun}, 32'h0);
        base = done_cnt;
        fork
            cpu_op(1'b1, 8'h30, 32'h0, 4'h0, 1'b0, lat_c);
            begin
                tick;
                expect_dbg(1'b0, 32'hCAFE0001);
                dbg_wr = 1'b1;
                dbg_wdata = 32'hCAFE0001;
                dbg_req = 1'b1;
                tick;
                dbg_wdata = 32'hCAFE0002;
                tick;
                dbg_req = 1'b0;
            end
        join
        chk("ovr_cpu_latency", lat_c, 3);
        wait_dones(base + 1, "ovr_done");
        repeat (6) tick;
        chk("ovr_single_done", done_cnt, base + 1);
        chk("overrun_set", {31'h0, dbg_overrun}, 32'h1);

        // Reset during the DBG_ACC cycle of a read aborts it.
        do_reset;
        chk("overrun_cleared", {31'h0, dbg_overrun}, 32'h0);
        base = done_cnt;
        dbg_wr = 1'b0;
        dbg_req = 1'b1;
        tick;
        dbg_req = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        mdl_ptr = 8'h00;
        repeat (6) tick;
        chk("abort_no_done", done_cnt, base);
        dbg_op(1'b1, 32'h0BADF00D, lat);
        chk("after_abort_latency", lat, 3);
        chk("ram_00", ram[8'h00], 32'h0BADF00D);

        // Without auto-increment the pointer stays put.
        dbg_auto_inc = 1'b0;
        dbg_op(1'b1, 32'h77770001, lat);
        dbg_op(1'b1, 32'h77770002, lat);
        chk("ram_01_noinc", ram[8'h01], 32'h77770002);

        repeat (3) tick;
        chk("exp_wr_empty", exp_wr.size(), 0);
        chk("exp_dbg_empty", exp_dbg.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
